hd44780_reader: RTL
===================

HD44780_READER -- requirements
Module: hd44780_reader

Interface
REQ-001 Parameter T_AS_CYC, default 2: cycles RS/RW are held stable before each E rise.
REQ-002 Parameter T_EH_CYC, default 12: cycles E is high per nibble.
REQ-003 Parameter T_EL_CYC, default 12: cycles E is low after each nibble.
REQ-004 Parameter ALIVE_BITS, default 23: width of the alive counter.
REQ-005 Port CLK_I, input, 1: the only clock; all logic on its rising edge.
REQ-006 Port RST_I, input, 1: reset; one clock, reset asynchronous and active-high.
REQ-007 Port STB_I, input, 1: single-cycle read request strobe.
REQ-008 Port DAT_I, input, 8: bit 0 selects RS (0 = busy flag/address counter, 1 = DDRAM/CGRAM data); bits 7:1 are ignored.
REQ-009 Port STB_O, output, 1: single-cycle completion strobe (ack).
REQ-010 Port DAT_O, output, 8: byte read from the LCD, ordered {first nibble, second nibble}.
REQ-011 Port o_busy, output, 1: high while a read is in progress.
REQ-012 Port o_bus_req, output, 1: high while this block owns the LCD pins, for arbitration with the writer.
REQ-013 Port o_lcd_rs, o_lcd_rw, o_lcd_e, output, 1 each: HD44780 control pins.
REQ-014 Port i_lcd_db, input, 4: LCD DB7..DB4 (4-bit mode).
REQ-015 Port o_alive, output, 1: free-running alive indicator, active high.

Function
REQ-016 States SHALL be IDLE, SETUP, EH1, EL1, EH2, EL2 and DONE.
REQ-017 IDLE: if STB_I = 1 at an edge, latch DAT_I[0] into RS and go to SETUP; otherwise remain in IDLE.
REQ-018 SETUP SHALL last T_AS_CYC cycles with o_lcd_rw = 1, o_lcd_rs = latched RS and o_lcd_e = 0.
REQ-019 EH1 and EH2 SHALL each last T_EH_CYC cycles with o_lcd_e = 1.
REQ-020 EL1 and EL2 SHALL each last T_EL_CYC cycles with o_lcd_e = 0.
REQ-021 i_lcd_db SHALL be sampled on the last cycle of EH1 (high nibble) and of EH2 (low nibble).
REQ-022 DONE SHALL last one cycle, with STB_O = 1 and DAT_O updated at entry; the block then returns to IDLE.
REQ-023 Latency: a request accepted at edge k SHALL produce STB_O high in the cycle after edge k + T_AS_CYC + 2*(T_EH_CYC + T_EL_CYC) + 1 (edge k+51 with defaults).
REQ-024 DAT_O SHALL hold its value until the next DONE.
REQ-025 o_busy and o_bus_req SHALL be high in every state except IDLE, including DONE.
REQ-026 In IDLE: o_lcd_rw = 0, o_lcd_e = 0, o_lcd_rs = 0.
REQ-027 STB_I SHALL be ignored (not queued) in any state except IDLE, including DONE.
REQ-028 A single phase down-counter SHALL time all states, reloaded on each state entry.
REQ-029 The counter width SHALL be sized for the largest of T_AS_CYC, T_EH_CYC and T_EL_CYC.
REQ-030 A parameter value of 0 SHALL be treated as 1.
REQ-031 The alive counter SHALL increment every cycle and wrap; o_alive = counter MSB.

Reset
REQ-032 While RST_I is high, the block SHALL immediately force: state = IDLE, o_lcd_e = 0, o_lcd_rw = 0, o_lcd_rs = 0, STB_O = 0, DAT_O = 0x00, o_busy = 0, o_bus_req = 0, alive counter = 0.
REQ-033 Reset asserted mid-read SHALL abort the read without producing STB_O, and SHALL drop E within the same cycle.
REQ-034 After RST_I deasserts, the first STB_I SHALL be accepted at the next edge.

Structure
REQ-035 The state encoding and the default timing constants SHALL live in shared package hd44780_pkg, which the writer also uses.
REQ-036 The phase counter MAY be the sub-module hd44780_phase_timer (load value, done flag); everything else SHALL be inline.

Verification
REQ-037 Reset, then STB_I with DAT_I = 0x00 while the LCD model drives 0x8 then 0x3 -> RS = 0, RW = 1, two E pulses of 12 cycles each, STB_O high for exactly one cycle at edge k+51, DAT_O = 0x83.
REQ-038 STB_I with DAT_I = 0x01, nibbles 0x4 then 0x1 -> RS = 1 throughout the read, DAT_O = 0x41.
REQ-039 Extra STB_I pulses during EH2 and during DONE -> no second read, exactly one STB_O, o_busy falls after DONE.
REQ-040 RST_I pulse at the 5th cycle of EH1 -> E = 0 in the same cycle, no STB_O, DAT_O = 0x00; the next request completes normally.
REQ-041 Nibbles change 1 cycle after the sampling edge -> DAT_O reflects the pre-change values, confirming last-cycle sampling.
REQ-042 Set T_AS_CYC = 0, T_EH_CYC = 1, T_EL_CYC = 1 -> STB_O at edge k+6; o_alive toggles every 2^(ALIVE_BITS-1) cycles.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared HD44780 bus definitions: FSM state encoding and default timing,
// used by both the reader and the writer.
package hd44780_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EH1   = 3'd2,
        ST_EL1   = 3'd3,
        ST_EH2   = 3'd4,
        ST_EL2   = 3'd5,
        ST_DONE  = 3'd6
    } hd_state_e;

    localparam int DEF_T_AS_CYC = 2;
    localparam int DEF_T_EH_CYC = 12;
    localparam int DEF_T_EL_CYC = 12;

    // A phase of zero cycles cannot be timed; it is stretched to one.
    function automatic int clamp_cyc(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hd44780_phase_timer.sv
// Phase down-counter: load with a cycle count on state entry; done is high
// during the last cycle of the phase.
module hd44780_phase_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val - W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/hd44780_reader.sv
// HD44780 4-bit read engine: on a request, clocks two nibbles out of the LCD
// (busy flag/address or RAM data) and returns them as one byte.
module hd44780_reader
    import hd44780_pkg::*;
#(
    parameter int T_AS_CYC   = DEF_T_AS_CYC,
    parameter int T_EH_CYC   = DEF_T_EH_CYC,
    parameter int T_EL_CYC   = DEF_T_EL_CYC,
    parameter int ALIVE_BITS = 23
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic       o_busy,
    output logic       o_bus_req,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    input  logic [3:0] i_lcd_db,
    output logic       o_alive
);

    localparam int AS_CYC = clamp_cyc(T_AS_CYC);
    localparam int EH_CYC = clamp_cyc(T_EH_CYC);
    localparam int EL_CYC = clamp_cyc(T_EL_CYC);
    localparam int CNT_W  = $clog2(max3(AS_CYC, EH_CYC, EL_CYC) + 1);

    localparam logic [CNT_W-1:0] AS_LD  = CNT_W'(AS_CYC);
    localparam logic [CNT_W-1:0] EH_LD  = CNT_W'(EH_CYC);
    localparam logic [CNT_W-1:0] EL_LD  = CNT_W'(EL_CYC);
    localparam logic [CNT_W-1:0] ONE_LD = CNT_W'(1);

    hd_state_e             state_q, state_d;
    logic                  rs_q;
    logic [3:0]            nib_hi_q, nib_lo_q;
    logic [ALIVE_BITS-1:0] alive_q;
    logic                  tmr_load, tmr_done;
    logic [CNT_W-1:0]      tmr_val;
    logic                  accept;
    logic                  busy_nxt, e_nxt;
    logic                  unused_dat;

    assign unused_dat = ^DAT_I[7:1];

    // Request handshake: STB_I is taken only when the FSM is idle and o_busy
    // is low, otherwise it is dropped (never queued); STB_O pulses for one
    // cycle with DAT_O valid, and DAT_O then holds until the next completion.
    assign accept = (state_q == ST_IDLE) && STB_I && !o_busy;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_val  = ONE_LD;
        busy_nxt = (state_q != ST_IDLE);
        e_nxt    = (state_q == ST_EH1) || (state_q == ST_EH2);
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_SETUP;
            ST_SETUP: if (tmr_done) state_d = ST_EH1;
            ST_EH1:   if (tmr_done) state_d = ST_EL1;
            ST_EL1:   if (tmr_done) state_d = ST_EH2;
            ST_EH2:   if (tmr_done) state_d = ST_EL2;
            ST_EL2:   if (tmr_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_SETUP:       tmr_val = AS_LD;
            ST_EH1, ST_EH2: tmr_val = EH_LD;
            ST_EL1, ST_EL2: tmr_val = EL_LD;
            default:        tmr_val = ONE_LD;
        endcase
    end

    assign tmr_load = (state_d != state_q);

    hd44780_phase_timer #(
        .W(CNT_W)
    ) u_timer (
        .i_clk   (CLK_I),
        .rst     (RST_I),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rs_q <= 1'b0;
        end else if (accept) begin
            rs_q <= DAT_I[0];
        end
    end

    // All pins are registered copies of the state decode, so they trail the
    // FSM by one cycle. A nibble is captured at the edge that ends the last
    // E-high cycle at the pin: the FSM has left EHx while the E register is
    // still high.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            o_busy    <= 1'b0;
            o_bus_req <= 1'b0;
            o_lcd_rw  <= 1'b0;
            o_lcd_rs  <= 1'b0;
            o_lcd_e   <= 1'b0;
            STB_O     <= 1'b0;
            DAT_O     <= 8'h00;
            nib_hi_q  <= 4'h0;
            nib_lo_q  <= 4'h0;
        end else begin
            o_busy    <= busy_nxt;
            o_bus_req <= busy_nxt;
            o_lcd_rw  <= busy_nxt;
            o_lcd_rs  <= busy_nxt & rs_q;
            o_lcd_e   <= e_nxt;
            STB_O     <= (state_q == ST_DONE);
            if ((state_q == ST_EL1) && o_lcd_e) nib_hi_q <= i_lcd_db;
            if ((state_q == ST_EL2) && o_lcd_e) nib_lo_q <= i_lcd_db;
            if (state_q == ST_DONE) DAT_O <= {nib_hi_q, nib_lo_q};
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            alive_q <= '0;
        end else begin
            alive_q <= alive_q + ALIVE_BITS'(1);
        end
    end

    assign o_alive = alive_q[ALIVE_BITS-1];

endmodule
